// File: rtl/reaction_timer_pkg.sv
// Shared types and default parameter values for the reaction timer.
package reaction_timer_pkg;

    localparam int unsigned RAND_W_DEF    = 10;
    localparam int unsigned MIN_DELAY_DEF = 16;
    localparam int unsigned RT_W_DEF      = 12;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        GO,
        DONE,
        FALSE
    } rt_state_e;

endpackage

// File: rtl/reaction_timer.sv
// One round of a reaction game: random wait, GO light, then response time measured in ticks.
// Presses before GO end the round as a false start.
module reaction_timer
    import reaction_timer_pkg::*;
#(
    parameter int unsigned RAND_W    = RAND_W_DEF,
    parameter int unsigned MIN_DELAY = MIN_DELAY_DEF,
    parameter int unsigned RT_W      = RT_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tick,
    input  logic              start,
    input  logic              press,
    input  logic [RAND_W-1:0] rand_val,
    output logic              led_go,
    output logic              done,
    output logic              false_start,
    output logic [RT_W-1:0]   reaction_time
);

    localparam int unsigned   DLY_W  = RAND_W + 1;
    localparam logic [RT_W-1:0] RT_MAX = '1;

    rt_state_e        state_q, state_d;
    logic [DLY_W-1:0] dly_cnt_q, dly_cnt_d;
    logic [RT_W-1:0]  rt_cnt_q, rt_cnt_d;
    logic [RT_W-1:0]  rt_res_q, rt_res_d;

    always_comb begin
        // NOTE: every next-state signal defaults to its current value first, so no path infers a latch.
        state_d   = state_q;
        dly_cnt_d = dly_cnt_q;
        rt_cnt_d  = rt_cnt_q;
        rt_res_d  = rt_res_q;

        unique case (state_q)
            IDLE, DONE, FALSE: begin
                if (start) begin
                    state_d   = WAIT;
                    dly_cnt_d = DLY_W'(MIN_DELAY) + DLY_W'(rand_val);
                    rt_cnt_d  = '0;
                    rt_res_d  = '0;
                end
            end
            WAIT: begin
                // A press wins over a coincident tick, leaving the delay count frozen.
                if (press) begin
                    state_d = FALSE;
                end else if (tick) begin
                    dly_cnt_d = dly_cnt_q - DLY_W'(1);
                    if (dly_cnt_q == DLY_W'(1)) begin
                        state_d = GO;
                    end
                end
            end
            GO: begin
                if (press) begin
                    state_d  = DONE;
                    rt_res_d = rt_cnt_q;
                end else if (tick) begin
                    if (rt_cnt_q == RT_MAX) begin
                        state_d  = DONE;
                        rt_res_d = RT_MAX;
                    end else begin
                        rt_cnt_d = rt_cnt_q + RT_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (reset) begin
            state_q   <= IDLE;
            dly_cnt_q <= '0;
            rt_cnt_q  <= '0;
            rt_res_q  <= '0;
        end else begin
            state_q   <= state_d;
            dly_cnt_q <= dly_cnt_d;
            rt_cnt_q  <= rt_cnt_d;
            rt_res_q  <= rt_res_d;
        end
    end

    assign led_go        = (state_q == GO);
    assign done          = (state_q == DONE);
    assign false_start   = (state_q == FALSE);
    assign reaction_time = rt_res_q;

endmodule

// File: tb/tb_reaction_timer.sv
// Scoreboard bench: two timers (RT_W=12 and RT_W=4) share stimulus; a round-level model
// predicts GO / DONE / FALSE events which a monitor matches against output rising edges.
module tb_reaction_timer;

    localparam int RAND_W    = 10;
    localparam int MIN_DELAY = 16;
    localparam int RTW0      = 12;
    localparam int RTW1      = 4;

    localparam int M_IDLE = 0;
    localparam int M_WAIT = 1;
    localparam int M_GO   = 2;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              tick = 1'b0;
    logic              start = 1'b0;
    logic              press = 1'b0;
    logic [RAND_W-1:0] rand_val = '0;

    logic            led_go0, done0, fs0;
    logic [RTW0-1:0] rt0;
    logic            led_go1, done1, fs1;
    logic [RTW1-1:0] rt1;

    always #5 clk = ~clk;

    reaction_timer #(.RAND_W(RAND_W), .MIN_DELAY(MIN_DELAY), .RT_W(RTW0)) dut0 (
        .clk(clk), .reset(reset), .tick(tick), .start(start), .press(press),
        .rand_val(rand_val), .led_go(led_go0), .done(done0),
        .false_start(fs0), .reaction_time(rt0)
    );

    reaction_timer #(.RAND_W(RAND_W), .MIN_DELAY(MIN_DELAY), .RT_W(RTW1)) dut1 (
        .clk(clk), .reset(reset), .tick(tick), .start(start), .press(press),
        .rand_val(rand_val), .led_go(led_go1), .done(done1),
        .false_start(fs1), .reaction_time(rt1)
    );

    typedef enum int {EV_GO = 0, EV_DONE = 1, EV_FALSE = 2} ev_kind_e;
    typedef struct {
        ev_kind_e kind;
        int       cyc;
        int       rt;
    } ev_t;

    ev_t q0[$];
    ev_t q1[$];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Round-level reference: ticks counted up since the round began.
    int m_mode[2]    = '{M_IDLE, M_IDLE};
    int m_target[2]  = '{0, 0};
    int m_waited[2]  = '{0, 0};
    int m_elapsed[2] = '{0, 0};
    int m_rtw[2]     = '{RTW0, RTW1};

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int d, input ev_kind_e k, input int r);
        ev_t e;
        e.kind = k;
        e.cyc  = cyc + 1;
        e.rt   = r;
        if (d == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    task automatic model_step(input bit rst, input bit s, input bit p, input bit t, input int rv);
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                m_mode[d] = M_IDLE;
            end else if (m_mode[d] == M_IDLE) begin
                if (s) begin
                    m_target[d] = MIN_DELAY + rv;
                    m_waited[d] = 0;
                    m_mode[d]   = M_WAIT;
                end
            end else if (m_mode[d] == M_WAIT) begin
                if (p) begin
                    m_mode[d] = M_IDLE;
                    push(d, EV_FALSE, 0);
                end else if (t) begin
                    m_waited[d]++;
                    if (m_waited[d] == m_target[d]) begin
                        m_mode[d]    = M_GO;
                        m_elapsed[d] = 0;
                        push(d, EV_GO, 0);
                    end
                end
            end else begin
                if (p) begin
                    m_mode[d] = M_IDLE;
                    push(d, EV_DONE, m_elapsed[d]);
                end else if (t) begin
                    m_elapsed[d]++;
                    if (m_elapsed[d] == (1 << m_rtw[d])) begin
                        m_mode[d] = M_IDLE;
                        push(d, EV_DONE, (1 << m_rtw[d]) - 1);
                    end
                end
            end
        end
    endtask

    task automatic drive(input bit rst, input bit s, input bit p, input bit t, input int rv);
        @(negedge clk);
        reset    = rst;
        start    = s;
        press    = p;
        tick     = t;
        rand_val = rv[RAND_W-1:0];
        model_step(rst, s, p, t, rv);
    endtask

    task automatic idle_cycles(input int n, input bit t);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, t, 0);
    endtask

    task automatic reset_and_check(input string tag);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 0);
        @(negedge clk);
        check({tag, "_led_go0"}, int'(led_go0), 0);
        check({tag, "_done0"},   int'(done0),   0);
        check({tag, "_fs0"},     int'(fs0),     0);
        check({tag, "_rt0"},     int'(rt0),     0);
        check({tag, "_led_go1"}, int'(led_go1), 0);
        check({tag, "_done1"},   int'(done1),   0);
        check({tag, "_fs1"},     int'(fs1),     0);
        check({tag, "_rt1"},     int'(rt1),     0);
    endtask

    task automatic match(input int d, input ev_kind_e k, input int rt);
        ev_t e;
        if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
            check($sformatf("unexpected_event_dut%0d", d), int'(k), -1);
        end else begin
            e = (d == 0) ? q0.pop_front() : q1.pop_front();
            check($sformatf("ev_kind_dut%0d", d),  int'(k), int'(e.kind));
            check($sformatf("ev_cycle_dut%0d", d), cyc,     e.cyc);
            check($sformatf("ev_rt_dut%0d", d),    rt,      e.rt);
        end
    endtask

    // Monitor: samples just after each rising edge and reports output rising edges as events.
    initial begin
        logic [2:0] prev0, prev1, cur0, cur1;
        prev0 = '0;
        prev1 = '0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            cur0 = {fs0, done0, led_go0};
            cur1 = {fs1, done1, led_go1};
            if (cur0[0] === 1'b1 && prev0[0] !== 1'b1) match(0, EV_GO,    int'(rt0));
            if (cur0[1] === 1'b1 && prev0[1] !== 1'b1) match(0, EV_DONE,  int'(rt0));
            if (cur0[2] === 1'b1 && prev0[2] !== 1'b1) match(0, EV_FALSE, int'(rt0));
            if (cur1[0] === 1'b1 && prev1[0] !== 1'b1) match(1, EV_GO,    int'(rt1));
            if (cur1[1] === 1'b1 && prev1[1] !== 1'b1) match(1, EV_DONE,  int'(rt1));
            if (cur1[2] === 1'b1 && prev1[2] !== 1'b1) match(1, EV_FALSE, int'(rt1));
            prev0 = cur0;
            prev1 = cur1;
        end
    end

    initial begin
        int rv, tmode, pp, len;
        bit s, p, t;

        // Reset, then stray press/tick pulses while idle must produce nothing.
        reset_and_check("reset");
        for (int i = 0; i < 6; i++) drive(1'b0, 1'b0, i[0], 1'b1, 0);
        reset_and_check("idle_presses");

        // Nominal round: rand_val=5, press 7 ticks after GO.
        drive(1'b0, 1'b1, 1'b0, 1'b1, 5);
        idle_cycles(21 + 7, 1'b1);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 0);
        idle_cycles(4, 1'b1);

        // False start: rand_val=100, press after 50 ticks; then a fresh round.
        drive(1'b0, 1'b1, 1'b0, 1'b1, 100);
        idle_cycles(50, 1'b1);
        drive(1'b0, 1'b0, 1'b1, 1'b1, 0);
        idle_cycles(3, 1'b1);
        drive(1'b0, 1'b1, 1'b0, 1'b1, 3);

        // Start during WAIT is ignored; press coincides with tick at rt_cnt=3.
        idle_cycles(5, 1'b1);
        drive(1'b0, 1'b1, 1'b0, 1'b1, 900);
        idle_cycles(19 - 6 + 3, 1'b1);
        drive(1'b0, 1'b0, 1'b1, 1'b1, 0);
        idle_cycles(3, 1'b1);

        // Timeout: the narrow counter saturates at 15, the wide one at 4095.
        drive(1'b0, 1'b1, 1'b0, 1'b1, 0);
        idle_cycles(16 + 4096 + 2, 1'b1);

        // Reset mid-WAIT and mid-GO aborts the round.
        drive(1'b0, 1'b1, 1'b0, 1'b1, 7);
        idle_cycles(5, 1'b1);
        reset_and_check("rst_wait");
        drive(1'b0, 1'b1, 1'b0, 1'b1, 2);
        idle_cycles(25, 1'b1);
        reset_and_check("rst_go");

        // Randomized rounds with varied tick gating and press density.
        for (int r = 0; r < 40; r++) begin
            rv    = (r % 8 == 0) ? int'($urandom_range(0, 1023)) : int'($urandom_range(0, 40));
            tmode = (rv > 40) ? 0 : int'($urandom_range(0, 2));
            case ($urandom_range(0, 3))
                0: pp = 0;
                1: pp = 2;
                2: pp = 8;
                default: pp = 30;
            endcase
            len = (MIN_DELAY + rv + 40) * ((tmode == 0) ? 1 : (tmode == 1) ? 4 : 2);
            for (int i = 0; i < len; i++) begin
                s = (i == 0) || ($urandom_range(0, 31) == 0);
                p = (i != 0) && ($urandom_range(0, 255) < pp);
                if (tmode == 0)      t = 1'b1;
                else if (tmode == 1) t = (i % 4 == 0);
                else                 t = $urandom_range(0, 1) == 1;
                drive(1'b0, s, p, t, (i == 0) ? rv : int'($urandom_range(0, 40)));
            end
        end

        // Drain: a press ends any open round, then let events settle.
        drive(1'b0, 1'b0, 1'b1, 1'b0, 0);
        idle_cycles(6, 1'b0);
        check("pending_events_dut0", q0.size(), 0);
        check("pending_events_dut1", q1.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
